cpu_stream_mem_writer: RTL and testbench

//   Upstream feeder for the 32-bit single-port on-chip RAM (cpu_onchip_memory2_0-class slave).

---
 rtl/cpu_stream_mem_writer_pkg.sv | 19 +
 rtl/cpu_byte_packer.sv | 61 ++++++
 rtl/cpu_stream_mem_writer.sv | 158 +++++++++++++++
 tb/tb_cpu_stream_mem_writer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_stream_mem_writer_pkg.sv
// Shared types and helpers for the byte-stream to 32-bit RAM writer.
package cpu_stream_mem_writer_pkg;

  // Job sequencing: idle, packing bytes, then one cycle to let the last write retire.
  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDrain
  } state_e;

  // Highest byte lane in a 32-bit word; accepting this lane closes the word.
  localparam logic [1:0] LANE_LAST = 2'd3;

  // Number of enabled byte lanes in a byteenable mask.
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/cpu_byte_packer.sv
// Packs an 8-bit byte stream little-endian into a 32-bit word with per-lane enables.
// The word/enable outputs already include the byte being accepted this cycle, so the
// parent can move them straight into its write register on a commit.
module cpu_byte_packer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic        commit_i,
  input  logic [7:0]  data_i,
  output logic [1:0]  lane_o,
  output logic [31:0] word_o,
  output logic [3:0]  be_o
);

  logic [31:0] data_q, data_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  lane_q, lane_d;

  assign lane_o = lane_q;

  // Merge the incoming byte into its lane so a commit sees the complete word.
  always_comb begin
    word_o = data_q;
    be_o   = be_q;
    if (accept_i) begin
      word_o[{lane_q, 3'b000} +: 8] = data_i;
      be_o[lane_q]                  = 1'b1;
    end
  end

  // Commit or clear empties the pack register; otherwise an accepted byte advances the lane.
  always_comb begin
    data_d = data_q;
    be_d   = be_q;
    lane_d = lane_q;
    if (clear_i || (accept_i && commit_i)) begin
      data_d = '0;
      be_d   = '0;
      lane_d = '0;
    end else if (accept_i) begin
      data_d = word_o;
      be_d   = be_o;
      lane_d = lane_q + 2'd1;
    end
  end

  // Pack state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= '0;
      be_q   <= '0;
      lane_q <= '0;
    end else begin
      data_q <= data_d;
      be_q   <= be_d;
      lane_q <= lane_d;
    end
  end

endmodule

// File: rtl/cpu_stream_mem_writer.sv
// Byte-stream to 32-bit on-chip RAM writer. Bytes arrive on a valid/ready stream, are packed
// little-endian into words and written one word per cycle from a programmed base word address.
// The RAM has no waitrequest, so the write register drains every cycle and packing never stalls.
module cpu_stream_mem_writer
  import cpu_stream_mem_writer_pkg::*;
#(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DEPTH  = 16640,
  parameter int unsigned LEN_W  = 17
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  byte_len_i,
  input  logic              abort_i,
  input  logic [7:0]        st_data_i,
  input  logic              st_valid_i,
  input  logic              st_eop_i,
  output logic              st_ready_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [3:0]        mem_byteenable_o,
  output logic              mem_chipselect_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_writedata_o,
  output logic              mem_clken_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [LEN_W-1:0]  bytes_written_o
);

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic [3:0]        wr_be_q;
  logic [LEN_W-1:0]  bytes_written_q;
  logic              error_q;
  logic              done_q;

  logic        acc;
  logic        last_byte;
  logic        commit;
  logic        pk_clear;
  logic [1:0]  pk_lane;
  logic [31:0] pk_word;
  logic [3:0]  pk_be;

  assign st_ready_o = (state_q == StFill);
  // Abort wins over a byte offered in the same cycle, so that byte is never taken.
  assign acc        = st_valid_i & st_ready_o & ~abort_i;
  assign last_byte  = (cnt_q + LEN_W'(1)) == len_q;
  assign commit     = acc & ((pk_lane == LANE_LAST) | last_byte | st_eop_i);
  // A partial word is dropped on abort; a fresh job always starts from lane 0.
  assign pk_clear   = ((state_q == StFill) & abort_i) | ((state_q == StIdle) & start_i);

  cpu_byte_packer u_packer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (pk_clear),
    .accept_i (acc),
    .commit_i (commit),
    .data_i   (st_data_i),
    .lane_o   (pk_lane),
    .word_o   (pk_word),
    .be_o     (pk_be)
  );

  // Job FSM, address/byte counters, write register and status flags.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      len_q           <= '0;
      cnt_q           <= '0;
      wr_valid_q      <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      wr_be_q         <= '0;
      bytes_written_q <= '0;
      error_q         <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      wr_valid_q <= commit;
      if (wr_valid_q) begin
        bytes_written_q <= bytes_written_q + LEN_W'(popcount4(wr_be_q));
      end
      if (commit) begin
        wr_addr_q <= addr_q;
        wr_data_q <= pk_word;
        wr_be_q   <= pk_be;
        addr_q    <= addr_q + ADDR_W'(1);
      end
      if (acc) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            len_q           <= byte_len_i;
            addr_q          <= base_addr_i;
            cnt_q           <= '0;
            error_q         <= 1'b0;
            bytes_written_q <= '0;
            if ({1'b0, base_addr_i} >= DEPTH_EXT) begin
              error_q <= 1'b1;
              state_q <= StDrain;
            end else if (byte_len_i == '0) begin
              state_q <= StDrain;
            end else begin
              state_q <= StFill;
            end
          end
        end
        StFill: begin
          if (abort_i) begin
            state_q <= StDrain;
          end else if (commit) begin
            if (last_byte || st_eop_i) begin
              state_q <= StDrain;
            end else if (addr_q == LAST_ADDR) begin
              // Word at the top of memory is still written, but nothing may follow it.
              error_q <= 1'b1;
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          // Any pending write is on the bus during this cycle.
          state_q <= StIdle;
          done_q  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_address_o    = wr_addr_q;
  assign mem_byteenable_o = wr_be_q;
  assign mem_writedata_o  = wr_data_q;
  // Suppress a pending strobe in the cycle reset is raised.
  assign mem_write_o      = wr_valid_q & ~reset_i;
  assign mem_chipselect_o = wr_valid_q & ~reset_i;
  assign mem_clken_o      = 1'b1;
  assign busy_o           = (state_q != StIdle);
  assign done_o           = done_q;
  assign error_o          = error_q;
  assign bytes_written_o  = bytes_written_q;

endmodule

// File: tb/tb_cpu_stream_mem_writer.sv
// Directed bench for cpu_stream_mem_writer with a word-level reference model and write monitor.
module tb_cpu_stream_mem_writer;

  localparam int ADDR_W = 15;
  localparam int DEPTH  = 16640;
  localparam int LEN_W  = 17;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              st_valid = 1'b0;
  logic              st_eop = 1'b0;
  logic [7:0]        st_data = 8'h00;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  byte_len = '0;
  logic              st_ready, mem_chipselect, mem_write, mem_clken, busy, done, error;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_writedata;
  logic [LEN_W-1:0]  bytes_written;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
  } wr_t;

  wr_t exp_q[$];
  wr_t act_q[$];

  always #5 clk = ~clk;

  cpu_stream_mem_writer dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .start_i          (start),
    .base_addr_i      (base_addr),
    .byte_len_i       (byte_len),
    .abort_i          (abort),
    .st_data_i        (st_data),
    .st_valid_i       (st_valid),
    .st_eop_i         (st_eop),
    .st_ready_o       (st_ready),
    .mem_address_o    (mem_address),
    .mem_byteenable_o (mem_byteenable),
    .mem_chipselect_o (mem_chipselect),
    .mem_write_o      (mem_write),
    .mem_writedata_o  (mem_writedata),
    .mem_clken_o      (mem_clken),
    .busy_o           (busy),
    .done_o           (done),
    .error_o          (error),
    .bytes_written_o  (bytes_written)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i + 1);
  endfunction

  // Reference: which words a job must write, given how many bytes the source offers,
  // where eop sits, and how many bytes are accepted before abort/reset cuts the job.
  task automatic model(input int base, input int len, input int n_feed, input int eop_idx,
                       input int cut_after, output bit exp_err, output int exp_bw);
    int  n;
    wr_t w;
    exp_q.delete();
    exp_err = 1'b0;
    exp_bw  = 0;
    if (base >= DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    n = (len < n_feed) ? len : n_feed;
    if (eop_idx >= 0 && eop_idx + 1 < n) n = eop_idx + 1;
    if (cut_after >= 0 && cut_after < n) n = (cut_after / 4) * 4;
    for (int k = 0; k * 4 < n; k++) begin
      w.addr = ADDR_W'(base + k);
      w.data = '0;
      w.be   = '0;
      for (int b = 0; b < 4 && k * 4 + b < n; b++) begin
        w.data[8*b +: 8] = pat(k * 4 + b);
        w.be[b]          = 1'b1;
        exp_bw++;
      end
      exp_q.push_back(w);
      if (base + k == DEPTH - 1 && (k + 1) * 4 < n) begin
        exp_err = 1'b1;
        break;
      end
    end
  endtask

  // Every cycle: strobes agree, clken is high, and each write matches the next expected word.
  always @(negedge clk) begin
    wr_t e;
    if (done === 1'b1) done_cnt++;
    chk("chipselect_vs_write", 64'(mem_chipselect), 64'(mem_write));
    chk("clken", 64'(mem_clken), 64'(1));
    if (mem_write === 1'b1) begin
      act_q.push_back({mem_address, mem_writedata, mem_byteenable});
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h be %b, no write required",
                 mem_address, mem_writedata, mem_byteenable);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(mem_address), 64'(e.addr));
        chk("wr_data", 64'(mem_writedata), 64'(e.data));
        chk("wr_be", 64'(mem_byteenable), 64'(e.be));
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_st_ready"}, 64'(st_ready), 64'(0));
    chk({tag, "_mem_write"}, 64'(mem_write), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_error"}, 64'(error), 64'(0));
    chk({tag, "_bytes_written"}, 64'(bytes_written), 64'(0));
    chk({tag, "_mem_address"}, 64'(mem_address), 64'(0));
    chk({tag, "_mem_be"}, 64'(mem_byteenable), 64'(0));
    chk({tag, "_mem_data"}, 64'(mem_writedata), 64'(0));
    chk({tag, "_mem_clken"}, 64'(mem_clken), 64'(1));
  endtask

  task automatic chk_wr(input string name, input int idx, input int addr,
                        input logic [31:0] data, input logic [3:0] be);
    if (idx >= act_q.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: write %0d not seen, only %0d writes", name, idx, act_q.size());
    end else begin
      chk({name, "_addr"}, 64'(act_q[idx].addr), 64'(addr));
      chk({name, "_data"}, 64'(act_q[idx].data), 64'(data));
      chk({name, "_be"}, 64'(act_q[idx].be), 64'(be));
    end
  endtask

  // Start a job, offer bytes one per cycle, optionally abort/reset/re-start, wait for done.
  task automatic run_job(input string tag, input int base, input int len, input int n_feed,
                         input int eop_idx, input int abort_after, input int rst_after,
                         input bit start_busy, output int lat);
    bit exp_err;
    int exp_bw;
    int i;
    int cyc;
    int d0;
    bit rdy;
    bit did_rst;
    model(base, len, n_feed, eop_idx, (rst_after >= 0) ? rst_after - 1 : abort_after,
          exp_err, exp_bw);
    act_q.delete();
    d0      = done_cnt;
    i       = 0;
    did_rst = 1'b0;
    @(negedge clk);
    #1;
    base_addr = ADDR_W'(base);
    byte_len  = LEN_W'(len);
    start     = 1'b1;
    @(posedge clk);
    for (cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) break;
      start = 1'b0;
      if (rst_after >= 0 && i == rst_after) begin
        st_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals({tag, "_after_reset"});
        reset   = 1'b0;
        did_rst = 1'b1;
        break;
      end
      st_valid = (i < n_feed);
      st_data  = pat(i);
      st_eop   = (i == eop_idx);
      abort    = (abort_after >= 0 && i == abort_after);
      if (start_busy && i == 2) begin
        start     = 1'b1;
        base_addr = 15'h0100;
        byte_len  = 17'd1;
      end
      rdy = st_ready;
      @(posedge clk);
      if (rdy && st_valid && !abort) i++;
    end
    lat      = cyc;
    st_valid = 1'b0;
    st_eop   = 1'b0;
    abort    = 1'b0;
    start    = 1'b0;
    if (!did_rst) begin
      if (done_cnt == d0) begin
        checks++;
        errors++;
        $display("FAIL %s_done_timeout: no done within 300 cycles, required a done pulse", tag);
      end
      chk({tag, "_error"}, 64'(error), 64'(exp_err));
      chk({tag, "_bytes_written"}, 64'(bytes_written), 64'(exp_bw));
      chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
      @(negedge clk);
      #1;
      chk({tag, "_done_one_cycle"}, 64'(done), 64'(0));
    end
    chk({tag, "_missing_writes"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;

    // Two full words; a second start mid-job must be ignored.
    run_job("aligned", 'h10, 8, 8, -1, -1, -1, 1'b1, lat);
    chk("aligned_nwrites", 64'(act_q.size()), 64'(2));
    chk_wr("aligned_w0", 0, 'h10, 32'h04030201, 4'b1111);
    chk_wr("aligned_w1", 1, 'h11, 32'h08070605, 4'b1111);
    chk("aligned_bw_lit", 64'(bytes_written), 64'(8));

    // Partial tail word.
    run_job("partial", 'h0, 6, 6, -1, -1, -1, 1'b0, lat);
    chk_wr("partial_w1", 1, 'h1, 32'h00000605, 4'b0011);
    chk("partial_bw_lit", 64'(bytes_written), 64'(6));

    // eop on the third byte of a long job.
    run_job("eop", 'h40, 100, 10, 2, -1, -1, 1'b0, lat);
    chk("eop_nwrites", 64'(act_q.size()), 64'(1));
    chk_wr("eop_w0", 0, 'h40, 32'h00030201, 4'b0111);
    chk("eop_ready_low", 64'(st_ready), 64'(0));

    // Job starting at the last word runs off the end of memory.
    run_job("range", DEPTH - 1, 8, 8, -1, -1, -1, 1'b0, lat);
    chk("range_nwrites", 64'(act_q.size()), 64'(1));
    chk_wr("range_w0", 0, DEPTH - 1, 32'h04030201, 4'b1111);
    chk("range_error_lit", 64'(error), 64'(1));

    // Zero-length job.
    run_job("len0", 'h5, 0, 4, -1, -1, -1, 1'b0, lat);
    chk("len0_done_latency", 64'(lat), 64'(2));
    chk("len0_nwrites", 64'(act_q.size()), 64'(0));

    // Base address beyond memory.
    run_job("oob", DEPTH, 4, 4, -1, -1, -1, 1'b0, lat);
    chk("oob_error_lit", 64'(error), 64'(1));
    chk("oob_nwrites", 64'(act_q.size()), 64'(0));

    // Abort after 5 bytes of 12: first word only, error cleared by this start.
    run_job("abort", 'h30, 12, 12, -1, 5, -1, 1'b0, lat);
    chk("abort_nwrites", 64'(act_q.size()), 64'(1));
    chk_wr("abort_w0", 0, 'h30, 32'h04030201, 4'b1111);
    chk("abort_error_lit", 64'(error), 64'(0));

    // Abort in the same cycle as the final byte: nothing committed.
    run_job("abort_last", 'h50, 4, 4, -1, 3, -1, 1'b0, lat);
    chk("abort_last_nwrites", 64'(act_q.size()), 64'(0));

    // Reset mid-job after 6 bytes.
    run_job("midrst", 'h20, 12, 12, -1, -1, 6, 1'b0, lat);
    chk("midrst_nwrites", 64'(act_q.size()), 64'(1));

    // Block works normally after the mid-job reset.
    run_job("post_rst", 'h60, 4, 4, -1, -1, -1, 1'b0, lat);
    chk_wr("post_rst_w0", 0, 'h60, 32'h04030201, 4'b1111);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
